// File: rtl/pipe_reg_start_if.sv
// Handshake and data bundle for the AES pipeline entry stage.
// The master drives plaintext/key in and consumes round-1 data.
// The slave is the entry stage itself.
interface pipe_reg_start_if #(
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [127:0]  pt_in;
   logic [127:0]  key_in;
   logic [7:0]    out0, out1, out2, out3, out4, out5, out6, out7;
   logic [7:0]    out8, out9, outA, outB, outC, outD, outE, outF;
   logic [127:0]  key_out;
   logic [7:0]    Rcon_out;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;

   modport master (
      output in_valid, pt_in, key_in, out_ready,
      input  in_ready, key_out, Rcon_out, out_valid, count,
      input  out0, out1, out2, out3, out4, out5, out6, out7,
      input  out8, out9, outA, outB, outC, outD, outE, outF
   );

   modport slave (
      input  in_valid, pt_in, key_in, out_ready,
      output in_ready, key_out, Rcon_out, out_valid, count,
      output out0, out1, out2, out3, out4, out5, out6, out7,
      output out8, out9, outA, outB, outC, outD, outE, outF
   );
endinterface

// File: rtl/pipe_reg_start.sv
// AES pipeline entry stage: buffers plaintext/key pairs in a small FIFO,
// applies the initial AddRoundKey on write and presents the head entry
// to round 1 tagged with the round-1 Rcon.
module pipe_reg_start #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [7:0]  RCON_FIRST = 8'h01
) (
   input logic             clock,
   input logic             reset_n,
   pipe_reg_start_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [255:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          alive;
   logic          push;
   logic          pop;
   logic [255:0]  head;
   logic [127:0]  state;

   // in_ready is gated by a registered out-of-reset flag rather than the raw
   // reset pin, so it is low throughout reset and depends only on flops.
   assign bus.in_ready  = alive & (count != CW'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   // Tracks that reset has been released; clears asynchronously with reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) alive <= 1'b0;
      else          alive <= 1'b1;
   end

   // Storage write: keep the key alongside the post-AddRoundKey state.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= {bus.key_in, bus.pt_in ^ bus.key_in};
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Head entry presented only while occupied; zeros mark a bubble.
   always_comb begin
      head = '0;
      if (bus.out_valid) head = mem[rd_ptr];
   end

   assign state        = head[127:0];
   assign bus.key_out  = head[255:128];
   assign bus.Rcon_out = bus.out_valid ? RCON_FIRST : 8'h00;
   assign bus.count    = count;

   assign bus.out0 = state[7:0];
   assign bus.out1 = state[15:8];
   assign bus.out2 = state[23:16];
   assign bus.out3 = state[31:24];
   assign bus.out4 = state[39:32];
   assign bus.out5 = state[47:40];
   assign bus.out6 = state[55:48];
   assign bus.out7 = state[63:56];
   assign bus.out8 = state[71:64];
   assign bus.out9 = state[79:72];
   assign bus.outA = state[87:80];
   assign bus.outB = state[95:88];
   assign bus.outC = state[103:96];
   assign bus.outD = state[111:104];
   assign bus.outE = state[119:112];
   assign bus.outF = state[127:120];
endmodule

// File: tb/tb_pipe_reg_start.sv
// Testbench for pipe_reg_start: directed scenarios plus random traffic,
// checked against a queue-based reference of the FIFO contents.
module tb_pipe_reg_start;
   localparam int unsigned DEPTH = 2;
   localparam logic [7:0]  RCON  = 8'h01;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   pipe_reg_start_if #(.DEPTH(DEPTH)) bus ();

   pipe_reg_start #(.DEPTH(DEPTH), .RCON_FIRST(RCON)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned  n_checks = 0;
   int unsigned  n_pass   = 0;
   logic [255:0] model_q[$];
   logic         hold_valid = 1'b0;
   logic [263:0] hold_snap;
   logic [127:0] a_pt, a_key;

   task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [127:0] dut_state();
      return {bus.outF, bus.outE, bus.outD, bus.outC, bus.outB, bus.outA, bus.out9, bus.out8,
              bus.out7, bus.out6, bus.out5, bus.out4, bus.out3, bus.out2, bus.out1, bus.out0};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_outputs();
      logic [255:0] h;
      int unsigned  n;
      n = model_q.size();
      h = (n != 0) ? model_q[0] : '0;
      check("count",     264'(bus.count),     264'(n));
      check("out_valid", 264'(bus.out_valid), 264'(n != 0));
      check("in_ready",  264'(bus.in_ready),  264'(n < DEPTH));
      check("rcon",      264'(bus.Rcon_out),  264'((n != 0) ? RCON : 8'h00));
      check("state",     264'(dut_state()),   264'(h[127:0]));
      check("key_out",   264'(bus.key_out),   264'(h[255:128]));
   endtask

   // One clock: check at the falling edge, then advance the reference across the rising edge.
   task automatic cycle();
      logic         do_push, do_pop;
      logic [255:0] data;
      logic [263:0] snap;
      check_outputs();
      snap = {bus.Rcon_out, bus.key_out, dut_state()};
      if (hold_valid) check("hold_stable", snap, hold_snap);
      hold_valid = bus.out_valid & ~bus.out_ready;
      hold_snap  = snap;
      do_push = bus.in_valid && (model_q.size() < DEPTH);
      do_pop  = bus.out_ready && (model_q.size() != 0);
      data    = {bus.key_in, bus.pt_in ^ bus.key_in};
      @(posedge clock);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(data);
      @(negedge clock);
   endtask

   task automatic send(input logic [127:0] pt, input logic [127:0] key);
      bus.pt_in    = pt;
      bus.key_in   = key;
      bus.in_valid = 1'b1;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < int'(DEPTH) + 2; i++) cycle();
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_count",     264'(bus.count),     264'(0));
      check("rst_out_valid", 264'(bus.out_valid), 264'(0));
      check("rst_rcon",      264'(bus.Rcon_out),  264'(0));
      check("rst_in_ready",  264'(bus.in_ready),  264'(0));
      check("rst_state",     264'(dut_state()),   264'(0));
      check("rst_key_out",   264'(bus.key_out),   264'(0));
      model_q.delete();
      hold_valid   = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.pt_in     = '0;
      bus.key_in    = '0;

      // Power-on reset.
      @(negedge clock);
      async_reset();
      cycle();

      // FIPS-197 vector with one-cycle presentation latency.
      send(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
      bus.out_ready = 1'b0;
      cycle();
      bus.in_valid = 1'b0;
      check("fips_out0",    264'(bus.out0),     264'(8'hf0));
      check("fips_out1",    264'(bus.out1),     264'(8'he0));
      check("fips_outF",    264'(bus.outF),     264'(8'h00));
      check("fips_key_out", 264'(bus.key_out),  264'(128'h000102030405060708090a0b0c0d0e0f));
      check("fips_rcon",    264'(bus.Rcon_out), 264'(8'h01));
      cycle();
      drain();

      // Fill with backpressure: A, B accepted, C held until a pop frees an entry.
      bus.out_ready = 1'b0;
      send(rand128(), rand128()); cycle();
      send(rand128(), rand128()); cycle();
      send(rand128(), rand128()); cycle();
      check("fill_count",    264'(bus.count),    264'(2));
      check("fill_in_ready", 264'(bus.in_ready), 264'(0));
      bus.out_ready = 1'b1;
      cycle();
      bus.out_ready = 1'b0;
      cycle();
      bus.in_valid = 1'b0;
      drain();

      // Simultaneous push and pop at count=1 across pointer wrap.
      bus.out_ready = 1'b0;
      send(rand128(), rand128()); cycle();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(rand128(), rand128());
         cycle();
         check("pp_count", 264'(bus.count), 264'(1));
      end
      drain();

      // Reset with two blocks buffered.
      bus.out_ready = 1'b0;
      send(rand128(), rand128()); cycle();
      send(rand128(), rand128()); cycle();
      async_reset();
      cycle();

      // Random traffic; sender holds data while not accepted.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         logic keep;
         keep = bus.in_valid && (model_q.size() >= DEPTH);
         if (!keep) begin
            bus.pt_in    = rand128();
            bus.key_in   = rand128();
            bus.in_valid = ($urandom_range(0, 3) != 0);
         end
         bus.out_ready = ($urandom_range(0, 2) == 0);
         cycle();
      end

      // Drain to empty: bubble outputs in the cycle count reaches 0.
      drain();
      check("empty_out_valid", 264'(bus.out_valid), 264'(0));
      check("empty_rcon",      264'(bus.Rcon_out),  264'(0));
      check("empty_state",     264'(dut_state()),   264'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
